sprite_line_sched: RTL and testbench

SPRITE_LINE_SCHED -- requirements
Module: sprite_line_sched

---
 rtl/sprite_pkg.sv | 23 ++
 rtl/sprite_line_sched.sv | 120 ++++++++++++
 tb/tb_sprite_line_sched.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite line scheduler.
// Holds the scheduler state set and the VGA timing defaults.
package sprite_pkg;

    localparam int H_TRIG_DEF   = 1280;
    localparam int V_TOTAL_DEF  = 525;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_CLEAR,
        ST_START,
        ST_SETTLE,
        ST_RUN
    } sched_state_e;

    // Line that follows v in a frame of v_total lines.
    function automatic logic [9:0] wrap_next_line(logic [9:0] v, int v_total);
        return (int'(v) == v_total - 1) ? 10'd0 : v + 10'd1;
    endfunction

endpackage

// File: rtl/sprite_line_sched.sv
// Per-line scheduler: on each horizontal trigger it drains the drawer, clears the
// back line buffer, kicks the sprite frontend and watches for lines that overrun.
module sprite_line_sched
    import sprite_pkg::*;
#(
    parameter int H_TRIG   = H_TRIG_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        fe_done,
    input  logic        draw_done,
    input  logic        clear_done,
    input  logic        commit_req,
    output logic        start_row,
    output logic [9:0]  next_vcount,
    output logic        clear_req,
    output logic        buf_sel,
    output logic        table_swap,
    output logic        commit_pending,
    output logic        overrun,
    output logic [15:0] overrun_cnt
);

    sched_state_e state_q, state_d;

    logic        start_row_q, start_row_d;
    logic [9:0]  next_vcount_q, next_vcount_d;
    logic        clear_req_q, clear_req_d;
    logic        buf_sel_q, buf_sel_d;
    logic        table_swap_q, table_swap_d;
    logic        pending_q, pending_d;
    logic        overrun_q, overrun_d;
    logic [15:0] overrun_cnt_q, overrun_cnt_d;

    logic trig;
    logic line_done;
    logic overrun_evt;
    logic swap_evt;

    assign trig      = (hcount == 11'(H_TRIG));
    // A trigger landing on the completion cycle still counts the line as finished.
    assign line_done = (state_q == ST_RUN) && fe_done && draw_done;
    assign overrun_evt = trig && (state_q != ST_IDLE) && !line_done;
    assign swap_evt  = trig && (vcount == 10'(V_ACTIVE - 1)) && (pending_q || commit_req);

    // State and output registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q       <= ST_IDLE;
            start_row_q   <= 1'b0;
            next_vcount_q <= 10'd0;
            clear_req_q   <= 1'b0;
            buf_sel_q     <= 1'b0;
            table_swap_q  <= 1'b0;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
            overrun_cnt_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            start_row_q   <= start_row_d;
            next_vcount_q <= next_vcount_d;
            clear_req_q   <= clear_req_d;
            buf_sel_q     <= buf_sel_d;
            table_swap_q  <= table_swap_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        if (trig) begin
            state_d = ST_DRAIN;
        end else begin
            unique case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_DRAIN:  if (draw_done)  state_d = ST_CLEAR;
                ST_CLEAR:  if (clear_done) state_d = ST_START;
                ST_START:  state_d = ST_SETTLE;
                ST_SETTLE: state_d = ST_RUN;
                ST_RUN:    if (line_done)  state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic; strobes are decoded from the upcoming state so they register cleanly.
    always_comb begin
        start_row_d   = (state_d == ST_START);
        clear_req_d   = (state_d == ST_CLEAR);
        table_swap_d  = swap_evt;
        buf_sel_d     = buf_sel_q ^ trig;
        next_vcount_d = trig ? wrap_next_line(vcount, V_TOTAL) : next_vcount_q;
        pending_d     = swap_evt ? 1'b0 : (pending_q || commit_req);
        overrun_d     = overrun_q || overrun_evt;
        overrun_cnt_d = overrun_cnt_q;
        if (overrun_evt && (overrun_cnt_q != 16'hFFFF)) begin
            overrun_cnt_d = overrun_cnt_q + 16'd1;
        end
    end

    assign start_row      = start_row_q;
    assign next_vcount    = next_vcount_q;
    assign clear_req      = clear_req_q;
    assign buf_sel        = buf_sel_q;
    assign table_swap     = table_swap_q;
    assign commit_pending = pending_q;
    assign overrun        = overrun_q;
    assign overrun_cnt    = overrun_cnt_q;

endmodule

// File: tb/tb_sprite_line_sched.sv
// Directed bench for sprite_line_sched: a line-level reference model is compared
// against the DUT every cycle, plus hand-computed spot values at key points.
module tb_sprite_line_sched;
    import sprite_pkg::*;

    localparam int HT = H_TRIG_DEF;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        fe_done, draw_done, clear_done, commit_req;
    logic        start_row, clear_req, buf_sel, table_swap, commit_pending, overrun;
    logic [9:0]  next_vcount;
    logic [15:0] overrun_cnt;

    sprite_line_sched dut (
        .clk            (clk),
        .reset          (reset),
        .hcount         (hcount),
        .vcount         (vcount),
        .fe_done        (fe_done),
        .draw_done      (draw_done),
        .clear_done     (clear_done),
        .commit_req     (commit_req),
        .start_row      (start_row),
        .next_vcount    (next_vcount),
        .clear_req      (clear_req),
        .buf_sel        (buf_sel),
        .table_swap     (table_swap),
        .commit_pending (commit_pending),
        .overrun        (overrun),
        .overrun_cnt    (overrun_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a line is open from its trigger until the frontend and
    // drawer are both idle after the row was started and settled.
    bit          m_valid = 0;
    bit          m_open, m_drained, m_cleared;
    int          m_age;
    bit [9:0]    m_nv;
    bit          m_buf, m_swap, m_pend, m_ovr;
    bit [15:0]   m_cnt;

    always @(posedge clk) begin
        bit t, complete, sw;
        if (reset) begin
            m_valid = 1; m_open = 0; m_drained = 0; m_cleared = 0; m_age = 0;
            m_nv = 0; m_buf = 0; m_swap = 0; m_pend = 0; m_ovr = 0; m_cnt = 0;
        end else begin
            t        = (int'(hcount) == HT);
            complete = m_open && m_cleared && (m_age >= 2) && fe_done && draw_done;
            sw       = t && (int'(vcount) == V_ACTIVE_DEF - 1) && (m_pend || commit_req);
            m_swap   = sw;
            m_pend   = sw ? 1'b0 : (m_pend || commit_req);
            if (t) begin
                if (m_open && !complete) begin
                    m_ovr = 1;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
                end
                m_open = 1; m_drained = 0; m_cleared = 0; m_age = 0;
                m_nv  = (int'(vcount) == V_TOTAL_DEF - 1) ? 10'd0 : vcount + 10'd1;
                m_buf = !m_buf;
            end else if (m_open) begin
                if (!m_drained) begin
                    if (draw_done) m_drained = 1;
                end else if (!m_cleared) begin
                    if (clear_done) begin m_cleared = 1; m_age = 0; end
                end else if (complete) begin
                    m_open = 0;
                end else if (m_age < 2) begin
                    m_age++;
                end
            end
        end
    end

    // Per-cycle comparison plus pulse counters, all sampled on the falling edge.
    int start_cnt = 0, clear_cyc = 0, swap_cnt = 0;

    always @(negedge clk) begin
        logic [31:0] exp_v, act_v;
        bit e_start, e_clr;
        if (m_valid) begin
            e_start = m_open && m_cleared && (m_age == 0);
            e_clr   = m_open && m_drained && !m_cleared;
            exp_v = {e_start, m_nv, e_clr, m_buf, m_swap, m_pend, m_ovr, m_cnt};
            act_v = {start_row, next_vcount, clear_req, buf_sel, table_swap,
                     commit_pending, overrun, overrun_cnt};
            check("cycle_model", act_v, exp_v);
        end
        start_cnt += int'(start_row);
        clear_cyc += int'(clear_req);
        swap_cnt  += int'(table_swap);
    end

    // Line-buffer clearer: answers clear_req after clr_delay cycles.
    int clr_delay = 3;
    int clr_age   = 0;
    always @(negedge clk) begin
        if (clear_req) begin
            clr_age++;
            clear_done = (clr_age >= clr_delay);
        end else begin
            clr_age    = 0;
            clear_done = 1'b0;
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_trig(int v);
        vcount = 10'(v);
        hcount = 11'(HT);
        tick();
        hcount = 11'd0;
    endtask

    task automatic wait_start(string name);
        bit found = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (start_row) begin found = 1; break; end
        end
        check({name, "_start_seen"}, 32'(found), 32'd1);
    endtask

    task automatic wait_clear(string name);
        bit found = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (clear_req) begin found = 1; break; end
        end
        check({name, "_clear_seen"}, 32'(found), 32'd1);
    endtask

    initial begin
        int s0, c0, w0;
        reset = 1; hcount = 0; vcount = 0;
        fe_done = 1; draw_done = 1; commit_req = 0; clear_done = 0;
        tick(3);
        check("rst_cnt", 32'(overrun_cnt), 32'd0);
        check("rst_nv", 32'(next_vcount), 32'd0);
        reset = 0;
        tick(2);

        // Basic line at vcount 10 with a 20-cycle frontend.
        s0 = start_cnt;
        do_trig(10);
        wait_start("l10");
        check("l10_nv", 32'(next_vcount), 32'd11);
        check("l10_buf", 32'(buf_sel), 32'd1);
        fe_done = 0;
        tick(20);
        fe_done = 1;
        tick(3);
        check("l10_one_start", 32'(start_cnt - s0), 32'd1);
        check("l10_no_ovr", 32'(overrun), 32'd0);

        // Frame wrap.
        c0 = clear_cyc;
        do_trig(524);
        wait_start("wrap");
        check("wrap_nv", 32'(next_vcount), 32'd0);
        check("wrap_cleared", 32'(clear_cyc - c0), 32'd3);
        tick(5);

        // Drawer busy for 50 cycles holds off the clear.
        draw_done = 0;
        c0 = clear_cyc;
        do_trig(20);
        tick(50);
        check("drain_hold", 32'(clear_cyc - c0), 32'd0);
        draw_done = 1;
        wait_clear("drain");
        wait_start("drain");
        tick(5);

        // Overrun: frontend still busy at the next trigger.
        do_trig(30);
        wait_start("ovr_a");
        fe_done = 0;
        tick(10);
        do_trig(31);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_cnt1", 32'(overrun_cnt), 32'd1);
        wait_clear("ovr_b");
        wait_start("ovr_b");
        check("ovr_b_nv", 32'(next_vcount), 32'd32);
        tick(5);

        // Trigger coincident with completion is not an overrun.
        fe_done = 1;
        do_trig(40);
        check("coinc_cnt", 32'(overrun_cnt), 32'd1);
        wait_start("coinc");
        tick(5);

        // Table commit at line 100, swap at the last visible line.
        w0 = swap_cnt;
        vcount = 10'd100;
        commit_req = 1;
        tick();
        commit_req = 0;
        check("commit_pend", 32'(commit_pending), 32'd1);
        tick(3);
        do_trig(479);
        check("swap_pulse", 32'(table_swap), 32'd1);
        check("swap_pend0", 32'(commit_pending), 32'd0);
        check("swap_nv", 32'(next_vcount), 32'd480);
        tick();
        check("swap_one", 32'(table_swap), 32'd0);
        wait_start("blank");
        tick(5);
        commit_req = 1;
        do_trig(479);
        commit_req = 0;
        check("coinc_swap", 32'(table_swap), 32'd1);
        check("coinc_pend", 32'(commit_pending), 32'd0);
        tick();
        check("coinc_pend2", 32'(commit_pending), 32'd0);
        check("swap_total", 32'(swap_cnt - w0), 32'd2);
        wait_start("blank2");
        tick(5);
        do_trig(479);
        check("no_swap", 32'(table_swap), 32'd0);
        wait_start("blank3");
        tick(5);

        // Reset in the middle of a clear.
        clr_delay = 1000;
        do_trig(50);
        wait_clear("rst_mid");
        commit_req = 1;
        tick();
        commit_req = 0;
        reset = 1;
        tick();
        check("rstm_clr", 32'(clear_req), 32'd0);
        check("rstm_outs", {start_row, buf_sel, table_swap, commit_pending, overrun, overrun_cnt},
              32'd0);
        reset = 0;
        clr_delay = 3;
        s0 = start_cnt;
        c0 = clear_cyc;
        tick(10);
        check("rstm_quiet", 32'(start_cnt - s0 + clear_cyc - c0), 32'd0);
        do_trig(60);
        wait_start("post_rst");
        check("post_rst_ovr", 32'(overrun), 32'd0);
        tick(5);

        // Trigger held every cycle: saturate the overrun counter.
        vcount = 10'd70;
        hcount = 11'(HT);
        tick(65540);
        hcount = 11'd0;
        tick(2);
        check("sat_cnt", 32'(overrun_cnt), 32'h0000FFFF);
        check("sat_flag", 32'(overrun), 32'd1);
        tick(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
